// File: rtl/sign_packer_if.sv
// Handshake bundle between the counter bank / write-back DMA and sign_packer.
// The packer connects through the slave modport; the environment drives through master.
interface sign_packer_if #(
  parameter int W_IN = 32
);
  logic              start;
  logic [W_IN-1:0]   sign_word;
  logic              sign_valid;
  logic [2*W_IN-1:0] stream_data;
  logic              stream_valid;
  logic              stream_ready;
  logic              stream_last;
  logic              busy;
  logic              done;
  logic              overflow;

  modport master (
    output start, sign_word, sign_valid, stream_ready,
    input  stream_data, stream_valid, stream_last, busy, done, overflow
  );

  modport slave (
    input  start, sign_word, sign_valid, stream_ready,
    output stream_data, stream_valid, stream_last, busy, done, overflow
  );
endinterface

// File: rtl/sign_packer.sv
// Packs pairs of 32-bit sign slices into 64-bit beats and streams them out of a
// small first-word-fall-through FIFO, tagging the final beat of each hypervector.
module sign_packer #(
  parameter int W_IN  = 32,
  parameter int NWORD = 32,
  parameter int DEPTH = 16
) (
  input logic          clk,
  input logic          rst,
  sign_packer_if.slave bus
);
  localparam int CW = $clog2(NWORD + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = 2 * W_IN;
  localparam logic [CW-1:0] LAST_IDX = CW'(NWORD - 1);

  typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [CW-1:0]   r_wordCnt;
  logic            r_halfValid;
  logic [W_IN-1:0] r_low;
  logic [BW:0]     r_mem [DEPTH];
  logic [PW-1:0]   r_wrPtr;
  logic [PW-1:0]   r_rdPtr;
  logic            r_done;
  logic            r_overflow;

  logic            w_empty;
  logic            w_full;
  logic            w_oneLeft;
  logic            w_pop;
  logic            w_accept;
  logic            w_isLast;
  logic            w_push;
  logic            w_pushOk;
  logic            w_drop;
  logic            w_drainExit;
  logic [BW-1:0]   w_pushData;
  logic [BW:0]     w_head;

  assign w_empty     = (r_wrPtr == r_rdPtr);
  assign w_full      = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_oneLeft   = ((r_rdPtr + PW'(1)) == r_wrPtr);
  assign w_pop       = !w_empty && bus.stream_ready;
  assign w_accept    = (r_state == PACK) && bus.sign_valid;
  assign w_isLast    = (r_wordCnt == LAST_IDX);
  assign w_push      = w_accept && (r_halfValid || w_isLast);
  assign w_pushData  = r_halfValid ? {bus.sign_word, r_low} : {{W_IN{1'b0}}, bus.sign_word};
  assign w_pushOk    = w_push && (!w_full || w_pop);
  assign w_drop      = w_push && !w_pushOk;
  // Leaving DRAIN on "FIFO empty after this edge" also covers a dropped last beat.
  assign w_drainExit = (r_state == DRAIN) && (w_empty || (w_pop && w_oneLeft));
  assign w_head      = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start)             w_nextState = PACK;
      PACK:    if (w_accept && w_isLast)  w_nextState = DRAIN;
      DRAIN:   if (w_drainExit)           w_nextState = IDLE;
      default:                            w_nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.busy         = (r_state != IDLE);
    bus.done         = r_done;
    bus.overflow     = r_overflow;
    bus.stream_valid = !w_empty;
    bus.stream_data  = w_empty ? '0 : w_head[BW-1:0];
    bus.stream_last  = !w_empty && w_head[BW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wordCnt   <= '0;
      r_halfValid <= 1'b0;
      r_low       <= '0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_done <= w_drainExit;
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if ((r_state == IDLE) && bus.start) begin
        r_wordCnt   <= '0;
        r_halfValid <= 1'b0;
        r_overflow  <= 1'b0;
      end else begin
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
        if (w_accept) begin
          r_wordCnt <= r_wordCnt + CW'(1);
          if (r_halfValid) begin
            r_halfValid <= 1'b0;
          end else if (!w_isLast) begin
            r_low       <= bus.sign_word;
            r_halfValid <= 1'b1;
          end
        end
      end
    end
  end

  // Storage needs no reset: the output mux hides stale entries while empty.
  always_ff @(posedge clk) begin
    if (w_pushOk) begin
      r_mem[r_wrPtr[AW-1:0]] <= {w_isLast, w_pushData};
    end
  end
endmodule

// File: doc/sign_packer.md
Name: sign_packer

Overview:
- Sits directly downstream of the per-dimension majority counters.
- Each time the counter bank exposes one 32-dimension slice of sign bits, the bank's owner strobes `sign_valid`.
- This block packs consecutive 32-bit slices into 64-bit beats, buffers them in a small FIFO, and streams them to the write-back DMA with a valid/ready handshake.
- It flags the final beat of each hypervector and reports completion and overflow.

Parameters:
- W_IN, 32, width of one sign slice (one bit per counter).
- NWORD, 32, slices per hypervector (1024 dimensions by default); any value ≥1, odd allowed.
- DEPTH, 16, FIFO depth in 64-bit beats; power of two, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse that begins packing a new hypervector
- sign_word  in  W_IN  sign bits from the counter bank; bit k = sign_bit of counter k
- sign_valid  in  1  sign_word is valid this cycle
- stream_data  out  2*W_IN  output beat; low half = earlier slice
- stream_valid  out  1  FIFO non-empty
- stream_ready  in  1  downstream accepts the beat
- stream_last  out  1  current beat is the final beat of the hypervector
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when the last beat is accepted
- overflow  out  1  sticky: a beat was dropped because the FIFO was full

Behaviour:
- Reset: rst=1 at a clock edge forces the following values. This applies mid-operation too, flushing the FIFO and the half register.
  - state=IDLE
  - word_cnt=0
  - half_valid=0
  - FIFO empty
  - stream_valid=0, stream_last=0, stream_data=0
  - busy=0, done=0, overflow=0
- States:
  - IDLE: start=1 → PACK, word_cnt←0, half_valid←0, overflow←0. sign_valid is ignored in IDLE.
  - PACK: each cycle with sign_valid=1 accepts one slice.
    - If half_valid=0 and the slice is not the last, store it in the low register and set half_valid←1.
    - If half_valid=1, push the beat {sign_word, low} and set half_valid←0.
    - If the accepted slice is slice NWORD-1 and half_valid=0 (odd NWORD), push {0, sign_word}.
    - A push that completes the vector carries last=1 → DRAIN.
    - word_cnt increments per accepted slice.
  - DRAIN: no slices accepted (sign_valid ignored). Waits until the last-tagged beat is popped, pulses done, then → IDLE.
- start outside IDLE is ignored.
- FIFO:
  - First-word-fall-through: stream_data/stream_last reflect the head entry.
  - stream_valid = !empty.
  - Pop on stream_valid & stream_ready.
  - Push when full is accepted only if a pop occurs the same cycle. Otherwise the beat is dropped and overflow←1 (sticky until rst or next start).
  - A dropped last-tagged beat still moves the state to DRAIN; the block then waits for the FIFO to empty, pulses done, and returns to IDLE.
  - Simultaneous push and pop on an empty FIFO is not possible: the pushed beat becomes visible the next cycle.
- Latency:
  - Second slice of a pair accepted at edge t → beat visible (stream_valid=1) after edge t+1... i.e. in cycle t+1.
  - done asserts in the cycle after the edge at which the last beat is popped, for exactly one cycle; busy falls in that same cycle.
- Widths:
  - word_cnt is $clog2(NWORD+1) bits.
  - FIFO pointers are $clog2(DEPTH)+1 bits (wrap bit distinguishes full from empty).
  - Occupancy never exceeds DEPTH.
- stream_data and stream_last are don't-care when stream_valid=0, but the bench may check them as 0 after reset.

Test Plan:
1. Reset, start, NWORD=4, feed slices 0x00000001, 0x00000002, 0x00000003, 0x00000004 on back-to-back cycles, stream_ready=1 → beats 0x00000002_00000001 (last=0), then 0x00000004_00000003 (last=1); done pulses once; busy=0 afterwards.
2. NWORD=3, slices 0xAAAAAAAA, 0x55555555, 0xFFFFFFFF → beats 0x55555555_AAAAAAAA, then 0x00000000_FFFFFFFF with last=1.
3. DEPTH=2, NWORD=8, stream_ready=0, eight slices → first two beats held, third and fourth dropped, overflow=1. Raise ready → exactly 2 beats out, then done pulses and state returns to IDLE.
4. FIFO full and stream_ready=1 on the cycle a new beat is pushed → no drop, overflow stays 0, beat order preserved.
5. Reset asserted mid-PACK after 3 slices → next cycle stream_valid=0, busy=0. A new start with 4 slices yields only the new data.
6. sign_valid pulses in IDLE and start pulses during PACK → no beats, no word_cnt change, active vector unaffected.
